fifo_level: RTL and testbench

Parametrised synchronous FIFO with occupancy reporting. It is the successor buffer for the UART RX/TX paths and adds:
- a fill-level output;
- programmable almost-full and almost-empty thresholds;
- sticky overflow/underflow error flags;
- a synchronous flush.

It sits between the UART receiver/transmitter and the host-side bus interface. It is a drop-in superset of the existing buffer semantics: first-word-fall-through read and single clock domain.

---
 rtl/uart_pkg.sv | 13 +
 rtl/fifo_mem.sv | 26 ++
 rtl/fifo_level.sv | 128 ++++++++++++
 tb/tb_fifo_level.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART buffering blocks.
package uart_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 4;
    localparam int AE_THRESH_DEF = 2;

    // Almost-full leaves two free slots by default.
    function automatic int af_thresh_def(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FWFT FIFO with level, thresholds, sticky errors and flush.
module fifo_level
    import uart_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AF_THRESH = af_thresh_def(ADDR_W),
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_L    = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_L    = AE_THRESH[ADDR_W:0];
    localparam logic            AF_RST  = (AF_THRESH == 0);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ae_q, ae_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;

    always_comb begin
        wr_ok   = wr & (~full_q | rd);
        rd_ok   = rd & ~empty_q;
        mem_we  = 1'b0;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            mem_we = wr_ok;
            if (wr_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_ok) begin
                rptr_d = rptr_q + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            ovf_d = ovf_q | (wr & ~wr_ok);
            udf_d = udf_q | (rd & empty_q);
        end

        // Flags follow the next level so they move in step with it.
        empty_d = (level_d == '0);
        full_d  = (level_d == DEPTH_L);
        ae_d    = (level_d <= AE_L);
        af_d    = (level_d >= AF_L);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= AF_RST;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q),
        .wdata (w_data),
        .raddr (rptr_q),
        .rdata (r_data)
    );

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_level.sv
// Directed test of fifo_level with default parameters (DEPTH=16).
module tb_fifo_level;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_level dut (
        .clk          (clk),
        .reset        (reset),
        .clr          (clr),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 0; rd = 0; clr = 0;
    endtask

    task automatic do_clr();
        idle(); clr = 1; tick(); clr = 0;
    endtask

    task automatic test_reset();
        idle(); w_data = 0; reset = 0;
        #12;
        reset = 1;
        tick();
        total++;
        if ({level, empty, full, almost_empty, almost_full, overflow, underflow}
            !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b",
                     level, empty, full, almost_empty, almost_full, overflow, underflow);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr = 1; w_data = 8'(i); tick();
            total++;
            if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i == 15)) begin
                bad++;
                $display("FAIL fill[%0d]: lvl=%0d af=%b f=%b want lvl=%0d", i, level,
                         almost_full, full, i + 1);
            end
        end
        w_data = 8'hFF; tick(); idle();
        total++;
        if (level !== 5'd16 || overflow !== 1'b1 || full !== 1'b1 || r_data !== 8'h00) begin
            bad++;
            $display("FAIL overflow: lvl=%0d ov=%b f=%b head=%h want 16 1 1 00",
                     level, overflow, full, r_data);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (r_data !== 8'(i)) begin
                bad++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, r_data, 8'(i));
            end
            rd = 1; tick();
            total++;
            if (level !== 5'(15 - i) || almost_empty !== (15 - i <= 2) || empty !== (i == 15)) begin
                bad++;
                $display("FAIL drain_lvl[%0d]: lvl=%0d ae=%b e=%b want lvl=%0d", i, level,
                         almost_empty, empty, 15 - i);
            end
        end
        tick(); idle();
        total++;
        if (underflow !== 1'b1 || level !== 5'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL underflow: un=%b lvl=%0d e=%b want 1 0 1", underflow, level, empty);
        end
    endtask

    task automatic test_wr_rd_empty();
        do_clr();
        total++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL clr_flags: un=%b ov=%b want 0 0", underflow, overflow);
        end
        wr = 1; rd = 1; w_data = 8'hA5; tick(); idle();
        total++;
        if (level !== 5'd1 || empty !== 1'b0 || underflow !== 1'b1 || r_data !== 8'hA5) begin
            bad++;
            $display("FAIL wr_rd_empty: lvl=%0d e=%b un=%b rd=%h want 1 0 1 a5",
                     level, empty, underflow, r_data);
        end
    endtask

    task automatic test_full_rdwr();
        do_clr();
        for (int i = 0; i < 16; i++) begin
            wr = 1; w_data = 8'(8'h10 + i); tick();
        end
        idle();
        total++;
        if (full !== 1'b1 || r_data !== 8'h10) begin
            bad++;
            $display("FAIL full_head: f=%b head=%h want 1 10", full, r_data);
        end
        wr = 1; rd = 1; w_data = 8'h3C; tick(); idle();
        total++;
        if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || r_data !== 8'h11) begin
            bad++;
            $display("FAIL full_rdwr: lvl=%0d f=%b ov=%b head=%h want 16 1 0 11",
                     level, full, overflow, r_data);
        end
        rd = 1;
        for (int i = 0; i < 15; i++) tick();
        idle();
        total++;
        if (r_data !== 8'h3C || level !== 5'd1) begin
            bad++;
            $display("FAIL full_rdwr_tail: head=%h lvl=%0d want 3c 1", r_data, level);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        do_clr();
        // Two pre-fill words leave the pointers off zero before the wrap.
        for (int i = 0; i < 20; i++) begin
            wr = 1; w_data = 8'(8'h40 + i);
            rd = (i % 3 == 2) && (q.size() > 0);
            if (rd) begin
                total++;
                if (r_data !== q[0]) begin
                    bad++;
                    $display("FAIL wrap_rd[%0d]: got %h want %h", i, r_data, q[0]);
                end
                void'(q.pop_front());
            end
            q.push_back(w_data);
            tick();
            total++;
            if (level !== 5'(q.size())) begin
                bad++;
                $display("FAIL wrap_lvl[%0d]: got %0d want %0d", i, level, q.size());
            end
        end
        wr = 0; rd = 1;
        while (q.size() > 0) begin
            total++;
            if (r_data !== q[0]) begin
                bad++;
                $display("FAIL wrap_drain: got %h want %h", r_data, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        idle();
        total++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end: e=%b un=%b want 1 0", empty, underflow);
        end
    endtask

    task automatic test_clr();
        do_clr();
        wr = 1;
        for (int i = 0; i < 17; i++) begin
            w_data = 8'(i); tick();
        end
        wr = 0; rd = 1;
        for (int i = 0; i < 11; i++) tick();
        idle();
        total++;
        if (level !== 5'd5 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL clr_setup: lvl=%0d ov=%b want 5 1", level, overflow);
        end
        clr = 1; wr = 1; w_data = 8'h77; tick(); idle();
        total++;
        if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || almost_empty !== 1'b1) begin
            bad++;
            $display("FAIL clr: lvl=%0d e=%b ov=%b ae=%b want 0 1 0 1",
                     level, empty, overflow, almost_empty);
        end
        tick();
        total++;
        if (level !== 5'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL clr_hold: lvl=%0d e=%b want 0 1", level, empty);
        end
    endtask

    task automatic test_reset_mid();
        wr = 1;
        for (int i = 0; i < 18; i++) begin
            w_data = 8'(i); tick();
        end
        total++;
        if (level !== 5'd16 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup: lvl=%0d ov=%b want 16 1", level, overflow);
        end
        #1 reset = 0;
        #1;
        total++;
        if ({level, empty, full, almost_empty, almost_full, overflow, underflow}
            !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b",
                     level, empty, full, almost_empty, almost_full, overflow, underflow);
        end
        idle();
        tick();
        reset = 1;
        tick();
        total++;
        if (level !== 5'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: lvl=%0d e=%b want 0 1", level, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wr_rd_empty();
        test_full_rdwr();
        test_wrap();
        test_clr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
